// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI slave slice.
package spi_pkg;

    localparam int unsigned SPI_WIDTH       = 8;
    localparam int unsigned SPI_SYNC_STAGES = 2;

    // SPI mode encoded as {CPOL, CPHA}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus local tx/rx handshake of the SPI slave.
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH
);

    logic             CPOL;
    logic             CPHA;
    logic             sclk;
    logic             ss;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;

    modport slave (
        input  CPOL, CPHA, sclk, ss, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy
    );

    modport master (
        output CPOL, CPHA, sclk, ss, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy
    );

endinterface

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync
    import spi_pkg::*;
#(
    parameter int unsigned STAGES = SPI_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] pipe;
    logic              prev;

    // synchronizer chain plus one flop of history for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe <= '0;
            prev <= 1'b0;
        end else begin
            pipe <= {pipe[STAGES-2:0], d};
            prev <= pipe[STAGES-1];
        end
    end

    assign q    = pipe[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampling SPI responder, all four CPOL/CPHA modes.
// Build option: define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting (default MSB-first).
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = SPI_WIDTH,
    parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam int unsigned      OUT_BIT  = 0;
`else
    localparam int unsigned      OUT_BIT  = WIDTH - 1;
`endif

    spi_state_e             state, state_next;
    spi_mode_e              mode_q;
    logic                   sclk_s, sclk_rise, sclk_fall;
    logic                   ss_s, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   mosi_s;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WIDTH-1:0]       tx_shift, tx_shifted, tx_buf;
    logic [WIDTH-1:0]       rx_shift, rx_next, rx_data;
    logic                   tx_full, tx_ready, tx_load;
    logic                   hold, reload, rx_valid;
    logic                   cpol, cpha, sclk_edge, leading, trailing;
    logic                   start, stop, sample, shift;
    logic                   miso_d, oe_d, busy_d;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk (clk), .rst (rst), .d (bus.sclk),
        .q   (sclk_s), .rise (sclk_rise), .fall (sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk (clk), .rst (rst), .d (bus.ss),
        .q   (ss_s), .rise (ss_rise), .fall (ss_fall)
    );

    // mosi only needs the same delay as sclk so sampled data lines up with the edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mosi_pipe <= '0;
        else      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], bus.mosi};
    end
    assign mosi_s = mosi_pipe[SYNC_STAGES-1];

    assign cpol      = mode_q[1];
    assign cpha      = mode_q[0];
    assign sclk_edge = sclk_rise | sclk_fall;
    assign leading   = sclk_edge & (sclk_s != cpol);
    assign trailing  = sclk_edge & (sclk_s == cpol);
    assign tx_ready  = ~tx_full;
    assign tx_load   = start | (shift & ~hold & reload);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next    = {mosi_s, rx_shift[WIDTH-1:1]};
    assign tx_shifted = {1'b0, tx_shift[WIDTH-1:1]};
`else
    assign rx_next    = {rx_shift[WIDTH-2:0], mosi_s};
    assign tx_shifted = {tx_shift[WIDTH-2:0], 1'b0};
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // next state, edge strobes and pin outputs; deselect wins over a coincident sclk edge
    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        sample     = 1'b0;
        shift      = 1'b0;
        miso_d     = 1'b0;
        oe_d       = 1'b0;
        busy_d     = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    start      = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                miso_d = tx_shift[OUT_BIT];
                oe_d   = 1'b1;
                busy_d = ~ss_s;
                if (ss_rise) begin
                    stop       = 1'b1;
                    state_next = IDLE;
                end else begin
                    sample = cpha ? trailing : leading;
                    shift  = cpha ? leading : trailing;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // datapath: holding register, shift registers, bit counter and word completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= MODE0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            tx_buf   <= '0;
            tx_full  <= 1'b0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            hold     <= 1'b0;
            reload   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (bus.tx_valid && tx_ready) begin
                tx_buf  <= bus.tx_data;
                tx_full <= 1'b1;
            end else if (tx_load) begin
                tx_full <= 1'b0;
            end
            if (start) begin
                mode_q  <= spi_mode_e'({bus.CPOL, bus.CPHA});
                bit_cnt <= '0;
                hold    <= bus.CPHA;
                reload  <= 1'b0;
            end
            if (stop) begin
                bit_cnt <= '0;
                hold    <= 1'b0;
                reload  <= 1'b0;
            end
            if (sample) begin
                rx_shift <= rx_next;
                if (bit_cnt == LAST_BIT) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                    reload   <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
            if (shift) begin
                if (hold)        hold     <= 1'b0;
                else if (reload) reload   <= 1'b0;
                else             tx_shift <= tx_shifted;
            end
            if (tx_load) tx_shift <= tx_full ? tx_buf : '0;
        end
    end

    assign bus.miso     = miso_d;
    assign bus.miso_oe  = oe_d;
    assign bus.busy     = busy_d;
    assign bus.tx_ready = tx_ready;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave) for the same 4-wire bus our spi_master drives.
- Oversamples sclk, ss and mosi in the system clock domain. Shifts in a WIDTH-bit word from mosi while shifting a pre-loaded word out on miso.
- Supports all four CPOL/CPHA modes. Presents received words to the local side with a one-cycle valid pulse, and accepts transmit words through a valid/ready holding register.

Parameters:
- WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, synchronizer flops on sclk/ss/mosi (minimum 2).

Ports:
- clk  in  1  system clock; must run at least 8x the sclk frequency.
- rst  in  1  asynchronous, active-low reset.
- CPOL  in  1  sclk idle level; captured at ss assertion.
- CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge; captured at ss assertion.
- sclk  in  1  serial clock from master.
- ss  in  1  slave select, active low.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master.
- miso_oe  out  1  output enable for the miso pad buffer; 1 while selected.
- tx_data  in  WIDTH  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high while selected (synchronized ss low).

Behaviour:
- Reset (rst=0, asynchronous): all outputs and registers to 0 except tx_ready=1; state IDLE.
- Synchronization:
  - sclk, ss and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the synchronized value with its previous registered value.
  - All internal actions occur in the cycle an edge is detected.
- Edge roles:
  - Leading edge = sclk leaving the CPOL level; trailing edge = sclk returning to it.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
- Transmit holding register:
  - Handshake completes when tx_valid && tx_ready; tx_ready then drops the next cycle.
  - tx_ready returns to 1 the cycle after the buffer moves into the shift register.
- FSM IDLE:
  - miso=0, miso_oe=0, busy=0.
  - On synchronized ss falling: capture CPOL/CPHA, bit_cnt=0, go ACTIVE.
  - Same cycle: load tx_shift from the buffer if full, else all zeros (underrun sends 0x00), and set hold=CPHA.
- FSM ACTIVE:
  - miso = tx_shift MSB; miso_oe=1; busy=1.
  - Sample edge: rx_shift <= {rx_shift[WIDTH-2:0], mosi_s}; bit_cnt increments.
  - Sample edge with bit_cnt==WIDTH-1: rx_data <= completed word, rx_valid=1 for one cycle, bit_cnt=0, set reload.
  - Shift edge priority, highest first:
    1. hold: clear hold, no shift.
    2. reload: load tx_shift from buffer (or zeros), clear reload.
    3. otherwise shift left by one.
  - Words repeat back-to-back while ss stays low.
- Deassertion:
  - Synchronized ss rising from any ACTIVE point returns to IDLE the same cycle.
  - A partial word is discarded: no rx_valid, bit_cnt=0.
  - A buffered but unconsumed tx word is retained.
- Other boundary rules:
  - sclk edges in IDLE are ignored.
  - CPOL/CPHA changes while ACTIVE are ignored.
  - tx_valid during ACTIVE fills the buffer for the next word.
  - rx_valid and a buffer load in the same cycle are independent.
- Latency: rx_valid rises SYNC_STAGES+1 clk cycles after the final sampling sclk edge at the pins.

Optional Feature:
- Macro: SPI_SLAVE_LSB_FIRST_EN.
- Defined: both shift registers operate LSB-first. miso = tx_shift[0], shifting right; rx bits enter at the MSB and shift right.
- Undefined: MSB-first as described above.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package spi_pkg:
  - SPI_WIDTH default (8).
  - Mode encodings MODE0..MODE3 as {CPOL,CPHA}.
  - FSM state typedef (IDLE, ACTIVE).
  - SYNC_STAGES default.
- One sub-module, spi_sync: parameterized synchronizer plus rise/fall edge detector, instantiated for sclk and ss. mosi uses the synchronizer only.

Test Plan:
- Mode 0, tx_data=0x3C preloaded, master sends 0xAA. Expect rx_data=0xAA, one rx_valid pulse, miso bits 0,0,1,1,1,1,0,0, tx_ready back to 1.
- Modes 1, 2 and 3, each with master sending 0x5A and slave sending 0xC3. Expect rx=0x5A and master receives 0xC3 in every mode.
- Back-to-back: ss held low for 16 clocks, buffer refilled with 0x81 after the first load. Expect two rx_valid pulses, with slave sending 0x3C then 0x81.
- Underrun: no tx_valid before ss falls. Expect miso=0x00 for the word and tx_ready stays 1.
- ss deasserted after 5 bits. Expect no rx_valid, busy=0, miso_oe=0; the next full transfer receives its word correctly.
- rst pulsed low mid-word, asynchronously between clk edges. Expect outputs immediately at reset values; the next transfer is clean.
- LSB_FIRST build: master sends 0x01 MSB-first. Expect rx_data=0x80.
